// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS coprocessor-0: CAUSE/EPC/INT_ENTER, interrupt latching, exception commit
module cp0_unit #(
  parameter int CAUSE_IDX     = 13,
  parameter int EPC_IDX       = 14,
  parameter int INT_ENTER_IDX = 15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        pipeline_ready_i,
  input  logic        int1_i,
  input  logic        int2_i,
  input  logic        int3_i,
  input  logic        int4_i,
  input  logic        int5_i,
  input  logic        int6_i,
  input  logic        int7_i,
  input  logic        s_syscall_i,
  input  logic [31:0] epc_in_i,
  input  logic [4:0]  reg_r_i,
  input  logic [31:0] reg_in_i,
  input  logic        reg_we_i,
  output logic [31:0] reg_out_o,
  output logic        s_int_o,
  output logic [31:0] epc_o,
  output logic [31:0] int_enter_o
);

  localparam logic [4:0] CauseSel    = 5'(CAUSE_IDX);
  localparam logic [4:0] EpcSel      = 5'(EPC_IDX);
  localparam logic [4:0] IntEnterSel = 5'(INT_ENTER_IDX);
  localparam logic [3:0] ExcSyscall  = 4'd8;

  logic [7:0]  im_q, im_d;
  logic [3:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] int_enter_q, int_enter_d;
  logic [7:1]  pending_q, pending_d;

  logic [7:1]  int_vec;
  logic [7:1]  irq;
  logic [7:1]  take_clr;
  logic [3:0]  take_exc;
  logic        sw_write;
  logic        s_int;

  assign int_vec  = {int7_i, int6_i, int5_i, int4_i, int3_i, int2_i, int1_i};
  assign irq      = pending_q & im_q[7:1];
  assign s_int    = pipeline_ready_i & (s_syscall_i | (|irq));
  assign sw_write = reg_we_i & pipeline_ready_i;

  // Lowest-numbered enabled pending line wins; scan high to low so the last hit is the lowest.
  always_comb begin
    take_exc = 4'd0;
    take_clr = '0;
    for (int k = 7; k >= 1; k--) begin
      if (irq[k]) begin
        take_exc    = 4'(k);
        take_clr    = '0;
        take_clr[k] = 1'b1;
      end
    end
  end

  always_comb begin
    im_d        = im_q;
    exc_d       = exc_q;
    epc_d       = epc_q;
    int_enter_d = int_enter_q;
    pending_d   = pending_q;

    if (sw_write) begin
      if (reg_r_i == CauseSel) begin
        im_d  = reg_in_i[15:8];
        exc_d = reg_in_i[5:2];
      end
      if (reg_r_i == EpcSel)      epc_d       = reg_in_i;
      if (reg_r_i == IntEnterSel) int_enter_d = reg_in_i;
    end

    // Exception entry overrides a same-cycle software write to CAUSE/EPC.
    if (s_int) begin
      epc_d = epc_in_i;
      im_d  = 8'd0;
      if (s_syscall_i) begin
        exc_d = ExcSyscall;
      end else begin
        exc_d     = take_exc;
        pending_d = pending_q & ~take_clr;
      end
    end

    // A new assertion re-arms the line even if it was just taken.
    pending_d = pending_d | int_vec;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      im_q        <= '0;
      exc_q       <= '0;
      epc_q       <= '0;
      int_enter_q <= '0;
      pending_q   <= '0;
    end else begin
      im_q        <= im_d;
      exc_q       <= exc_d;
      epc_q       <= epc_d;
      int_enter_q <= int_enter_d;
      pending_q   <= pending_d;
    end
  end

  always_comb begin
    reg_out_o = 32'd0;
    if (reg_r_i == CauseSel)         reg_out_o = {16'd0, im_q, 2'b00, exc_q, 2'b00};
    else if (reg_r_i == EpcSel)      reg_out_o = epc_q;
    else if (reg_r_i == IntEnterSel) reg_out_o = int_enter_q;
  end

  assign s_int_o     = s_int;
  assign epc_o       = epc_q;
  assign int_enter_o = int_enter_q;

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - directed scoreboard bench for cp0_unit
module tb_cp0_unit;

  localparam logic [4:0] CAUSE = 5'd13;
  localparam logic [4:0] EPC   = 5'd14;
  localparam logic [4:0] IENT  = 5'd15;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [7:1]  ints;
  logic        syscall;
  logic [31:0] epc_in;
  logic [4:0]  reg_r;
  logic [31:0] reg_in;
  logic        reg_we;
  logic [31:0] reg_out;
  logic        s_int;
  logic [31:0] epc;
  logic [31:0] int_enter;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  cp0_unit dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .pipeline_ready_i (ready),
    .int1_i           (ints[1]),
    .int2_i           (ints[2]),
    .int3_i           (ints[3]),
    .int4_i           (ints[4]),
    .int5_i           (ints[5]),
    .int6_i           (ints[6]),
    .int7_i           (ints[7]),
    .s_syscall_i      (syscall),
    .epc_in_i         (epc_in),
    .reg_r_i          (reg_r),
    .reg_in_i         (reg_in),
    .reg_we_i         (reg_we),
    .reg_out_o        (reg_out),
    .s_int_o          (s_int),
    .epc_o            (epc),
    .int_enter_o      (int_enter)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h expected <entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [31:0] v);
    reg_r = idx;
    push_exp(tag, v);
    #1;
    chk(reg_out);
  endtask

  task automatic chk_sint(input string tag, input logic v);
    push_exp(tag, {31'd0, v});
    #1;
    chk({31'd0, s_int});
  endtask

  task automatic chk_epc(input string tag, input logic [31:0] v);
    push_exp(tag, v);
    #1;
    chk(epc);
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    reg_r  = idx;
    reg_in = d;
    reg_we = 1'b1;
    step();
    reg_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ready = 1'b1; ints = '0; syscall = 1'b0;
    epc_in = 32'd0; reg_r = 5'd0; reg_in = 32'd0; reg_we = 1'b0;
    @(negedge clk);
    step();
    reset = 1'b0;

    chk_reg("rst_cause", CAUSE, 32'h0);
    chk_reg("rst_epc", EPC, 32'h0);
    chk_reg("rst_ient", IENT, 32'h0);
    chk_sint("rst_sint", 1'b0);

    wr(5'd3, 32'hDEADBEEF);
    chk_reg("unknown_idx", 5'd3, 32'h0);
    wr(CAUSE, 32'hF0F0F0F0);
    chk_reg("cause_mask", CAUSE, 32'h0000F030);
    wr(EPC, 32'hF0F0F0F0);
    chk_reg("epc_rw", EPC, 32'hF0F0F0F0);
    wr(IENT, 32'hF0F0F0F0);
    chk_reg("ient_rw", IENT, 32'hF0F0F0F0);
    push_exp("ient_port", 32'hF0F0F0F0); #1; chk(int_enter);
    wr(CAUSE, 32'h0);

    // INT1 latched while masked, fires once IM opens
    ints[1] = 1'b1;
    chk_sint("int1_pulse_sint", 1'b0);
    step();
    ints = '0;
    chk_sint("int1_masked", 1'b0);
    wr(CAUSE, 32'h0000FF00);
    epc_in = 32'h80808080;
    chk_sint("int1_taken", 1'b1);
    step();
    chk_reg("int1_cause", CAUSE, 32'h00000004);
    chk_epc("int1_epc", 32'h80808080);
    chk_sint("int1_cleared", 1'b0);

    // INT2 and INT3 together: lowest first
    wr(CAUSE, 32'h0000FF00);
    ints[2] = 1'b1; ints[3] = 1'b1;
    step();
    ints = '0;
    epc_in = 32'h00001000;
    chk_sint("int23_sint", 1'b1);
    step();
    chk_reg("int2_first", CAUSE, 32'h00000008);
    chk_sint("int3_masked", 1'b0);
    wr(CAUSE, 32'h0000FF00);
    chk_sint("int3_sint", 1'b1);
    step();
    chk_reg("int3_next", CAUSE, 32'h0000000C);

    // SYSCALL ignores IM
    syscall = 1'b1;
    epc_in = 32'h00002000;
    chk_sint("sys_sint", 1'b1);
    step();
    syscall = 1'b0;
    chk_reg("sys_cause", CAUSE, 32'h00000020);
    chk_epc("sys_epc", 32'h00002000);

    // Not ready: no S_INT, no writes, pending still accumulates
    wr(CAUSE, 32'h0000FF00);
    ready = 1'b0;
    reg_we = 1'b1; reg_r = EPC; reg_in = 32'h55555555;
    ints[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_sint($sformatf("stall_%0d", i), 1'b0);
      step();
      ints = '0;
    end
    reg_we = 1'b0;
    ready = 1'b1;
    chk_epc("stall_no_write", 32'h00002000);
    epc_in = 32'h00003000;
    chk_sint("stall_release", 1'b1);
    step();
    chk_reg("stall_cause", CAUSE, 32'h00000004);
    chk_epc("stall_epc", 32'h00003000);

    // Exception beats a same-cycle CAUSE write
    wr(CAUSE, 32'h0000FF00);
    ints[5] = 1'b1;
    step();
    ints = '0;
    reg_we = 1'b1; reg_r = CAUSE; reg_in = 32'h0000FF00;
    epc_in = 32'h00004000;
    chk_sint("int5_sint", 1'b1);
    step();
    reg_we = 1'b0;
    chk_reg("int5_beats_write", CAUSE, 32'h00000014);
    chk_epc("int5_epc", 32'h00004000);

    // Same-cycle INT_ENTER write still lands
    wr(CAUSE, 32'h0000FF00);
    ints[6] = 1'b1;
    step();
    ints = '0;
    reg_we = 1'b1; reg_r = IENT; reg_in = 32'hABCD0000;
    chk_sint("int6_sint", 1'b1);
    step();
    reg_we = 1'b0;
    chk_reg("int6_ient_lands", IENT, 32'hABCD0000);
    chk_reg("int6_cause", CAUSE, 32'h00000018);

    // Set wins over clear on the taking edge
    wr(CAUSE, 32'h0000FF00);
    ints[1] = 1'b1;
    step();
    chk_sint("rearm_sint", 1'b1);
    step();
    ints = '0;
    chk_reg("rearm_cause", CAUSE, 32'h00000004);
    wr(CAUSE, 32'h0000FF00);
    chk_sint("rearm_fires", 1'b1);
    step();

    // Reset clears pending as well
    ints[2] = 1'b1;
    step();
    ints = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reg("rst2_cause", CAUSE, 32'h0);
    chk_reg("rst2_epc", EPC, 32'h0);
    chk_reg("rst2_ient", IENT, 32'h0);
    wr(CAUSE, 32'h0000FF00);
    chk_sint("rst2_no_pending", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
